// File: rtl/dir_link.sv
// dir_link: exchanges snake directions with a remote board over a byte UART.
//
// TX: every rising edge of the game tick (clk_div) captures dir1 into a
// one-deep pending slot. The transmitter sends each captured value as a two
// byte frame, HEADER then {0, ~code, 0, code}. A newer tick overwrites a value
// that has not been picked up yet.
// RX: waits for HEADER, then checks the next byte. A valid payload updates
// dir2 and pulses rcvdir. A bad payload, a repeated HEADER, or a silent gap
// of RX_TIMEOUT cycles sets the sticky frame_err flag.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst_n     synchronous active-low reset
//   clk_div   game tick; its rising edge queues one TX frame
//   dir1      local direction to transmit (NONE=0 UP=1 DOWN=2 LEFT=3 RIGHT=4)
//   rx_data   byte from the UART receiver
//   rx_valid  one-cycle strobe qualifying rx_data
//   tx_busy   UART transmitter busy
//   tx_data   byte to the UART transmitter
//   tx_start  one-cycle transmit request
//   dir2      last valid remote direction
//   rcvdir    one-cycle pulse per valid received frame
//   frame_err sticky receive error flag, cleared only by reset
module dir_link #(
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int unsigned RX_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_div,
  input  logic [2:0] dir1,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic [2:0] dir2,
  output logic       rcvdir,
  output logic       frame_err
);

  localparam int unsigned      CNT_W    = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    T_IDLE,
    T_HDR,
    T_HDR_WAIT,
    T_PAY,
    T_PAY_WAIT
  } tx_state_t;

  typedef enum logic {
    R_IDLE,
    R_PAY
  } rx_state_t;

  tx_state_t        tx_state, tx_state_nxt;
  rx_state_t        rx_state, rx_state_nxt;

  logic             clk_div_prv;
  logic             div_edge;
  logic             pending, pending_nxt;
  logic [2:0]       pend_dir, pend_dir_nxt;
  logic [2:0]       send_dir, send_dir_nxt;
  logic [7:0]       tx_data_nxt;
  logic             tx_start_nxt;
  logic             take_pending;

  logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
  logic [2:0]       dir2_nxt;
  logic             rcvdir_nxt;
  logic             frame_err_nxt;
  logic             pay_ok;

  assign div_edge = clk_div & ~clk_div_prv;

  // Payload: bit7=0, bit3=0, upper nibble is the complement of the code,
  // code within NONE..RIGHT.
  assign pay_ok = ~rx_data[7] & ~rx_data[3] &
                  (rx_data[6:4] == ~rx_data[2:0]) &
                  (rx_data[2:0] <= 3'd4);

  // Pending slot: a new tick wins over the transmitter taking the old value.
  always_comb begin
    pending_nxt  = pending;
    pend_dir_nxt = pend_dir;
    if (div_edge) begin
      pending_nxt  = 1'b1;
      pend_dir_nxt = dir1;
    end else if (take_pending) begin
      pending_nxt  = 1'b0;
    end
  end

  // TX FSM. tx_start is registered, so it is high exactly during the first
  // cycle of a _WAIT state; using it as the "first cycle" marker lets the
  // FSM ignore a tx_busy that the UART has not raised yet.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    send_dir_nxt = send_dir;
    take_pending = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (pending) begin
          take_pending = 1'b1;
          send_dir_nxt = pend_dir;
          tx_state_nxt = T_HDR;
        end
      end
      T_HDR: begin
        if (!tx_busy) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = HEADER;
          tx_state_nxt = T_HDR_WAIT;
        end
      end
      T_HDR_WAIT: begin
        if (!tx_start && !tx_busy) tx_state_nxt = T_PAY;
      end
      T_PAY: begin
        if (!tx_busy) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = {1'b0, ~send_dir, 1'b0, send_dir};
          tx_state_nxt = T_PAY_WAIT;
        end
      end
      T_PAY_WAIT: begin
        if (!tx_start && !tx_busy) tx_state_nxt = T_IDLE;
      end
      default: tx_state_nxt = T_IDLE;
    endcase
  end

  // RX FSM
  always_comb begin
    rx_state_nxt  = rx_state;
    to_cnt_nxt    = to_cnt;
    dir2_nxt      = dir2;
    rcvdir_nxt    = 1'b0;
    frame_err_nxt = frame_err;
    case (rx_state)
      R_IDLE: begin
        if (rx_valid && rx_data == HEADER) begin
          rx_state_nxt = R_PAY;
          to_cnt_nxt   = '0;
        end
      end
      R_PAY: begin
        if (rx_valid) begin
          if (rx_data == HEADER) begin
            // resync on a repeated header: stay and restart the timeout
            frame_err_nxt = 1'b1;
            to_cnt_nxt    = '0;
          end else if (pay_ok) begin
            dir2_nxt     = rx_data[2:0];
            rcvdir_nxt   = 1'b1;
            rx_state_nxt = R_IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            rx_state_nxt  = R_IDLE;
          end
        end else if (to_cnt == CNT_LAST) begin
          frame_err_nxt = 1'b1;
          rx_state_nxt  = R_IDLE;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      default: rx_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_div_prv <= 1'b1;
      pending     <= 1'b0;
      pend_dir    <= '0;
      send_dir    <= '0;
      tx_state    <= T_IDLE;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      rx_state    <= R_IDLE;
      to_cnt      <= '0;
      dir2        <= '0;
      rcvdir      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      clk_div_prv <= clk_div;
      pending     <= pending_nxt;
      pend_dir    <= pend_dir_nxt;
      send_dir    <= send_dir_nxt;
      tx_state    <= tx_state_nxt;
      tx_start    <= tx_start_nxt;
      tx_data     <= tx_data_nxt;
      rx_state    <= rx_state_nxt;
      to_cnt      <= to_cnt_nxt;
      dir2        <= dir2_nxt;
      rcvdir      <= rcvdir_nxt;
      frame_err   <= frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_dir_link.sv
// Bench for dir_link: RX vector table, hand-written multi-cycle sequences
// (timeout, TX framing, pending overwrite, reset mid-frame) and random RX/TX
// traffic checked against a byte-level reference model.
module tb_dir_link;

  localparam logic [7:0]  HDR = 8'hA5;
  localparam int unsigned TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_div = 1'b1;
  logic [2:0] dir1 = '0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [2:0] dir2;
  logic       rcvdir;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  logic prev_start = 1'b0;
  logic [7:0] txq[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [2:0] e_dir;
    logic       e_rcv;
    logic       e_err;
  } rxvec_t;

  rxvec_t tbl[23];

  always #5 clk = ~clk;

  dir_link #(.HEADER(HDR), .RX_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_div   (clk_div),
    .dir1      (dir1),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .dir2      (dir2),
    .rcvdir    (rcvdir),
    .frame_err (frame_err)
  );

  // UART transmitter model: busy for 10 cycles after each accepted start
  always @(posedge clk) begin
    if (!rst_n)              busy_cnt <= 0;
    else if (tx_start)       busy_cnt <= 10;
    else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // TX monitor: records every transmitted byte and checks the handshake
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      check("tx_start_one_cycle", {31'd0, prev_start}, 32'd0);
      check("tx_start_while_busy", busy_cnt, 32'd0);
      txq.push_back(tx_data);
    end
    prev_start = tx_start;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] enc(input int d);
    return 8'((7 - d) * 16 + d);
  endfunction

  function automatic bit pay_valid(input int b);
    return (b < 128) && ((b / 8) % 2 == 0) && ((b % 8) <= 4) &&
           (((b / 16) % 8) == 7 - (b % 8));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_div(input int d);
    dir1    = 3'(d);
    clk_div = 1'b1;
    tick();
    clk_div = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (txq.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("tx_wait_bytes", {31'd0, txq.size() >= n}, 32'd1);
  endtask

  task automatic check_rx(input string tag, input logic [2:0] ed, input logic er, input logic ee);
    check({tag, "_dir2"}, dir2, ed);
    check({tag, "_rcvdir"}, rcvdir, er);
    check({tag, "_frame_err"}, frame_err, ee);
  endtask

  initial begin
    int base;
    int m_dir, m_idle, quiet;
    bit m_err, m_in, e_rcv, v;
    logic [7:0] b;
    logic [7:0] expq[$];
    int rcv_seen;

    //             v     data   dir2  rcv   err
    tbl[0]  = '{1'b1, 8'hA5, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h61, 3'd1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 3'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h33, 3'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'h52, 3'd1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'hA5, 3'd1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'h11, 3'd1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 3'd1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 8'hA5, 3'd1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 3'd1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 8'h52, 3'd2, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 3'd2, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 8'hA5, 3'd2, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 8'hA5, 3'd2, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 8'h43, 3'd3, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 8'hA5, 3'd3, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 8'h25, 3'd3, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 8'hA5, 3'd3, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 8'hE1, 3'd3, 1'b0, 1'b1};
    tbl[19] = '{1'b1, 8'h70, 3'd3, 1'b0, 1'b1};
    tbl[20] = '{1'b1, 8'hA5, 3'd3, 1'b0, 1'b1};
    tbl[21] = '{1'b1, 8'h70, 3'd0, 1'b1, 1'b1};
    tbl[22] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1};

    // Reset values, with clk_div held high through reset release
    repeat (2) tick();
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check_rx("rst", 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (40) tick();
    check("no_spurious_frame", txq.size(), 0);
    clk_div = 1'b0;
    tick();

    // RX vector table
    for (int i = 0; i < 23; i++) begin
      rx_valid = tbl[i].v;
      rx_data  = tbl[i].d;
      tick();
      check_rx($sformatf("vec%0d", i), tbl[i].e_dir, tbl[i].e_rcv, tbl[i].e_err);
    end
    rx_valid = 1'b0;

    // RX timeout boundary
    do_reset();
    send(HDR);
    send(8'h61);
    check_rx("to_setup", 3'd1, 1'b1, 1'b0);
    send(HDR);
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      tick();
      check("to_before_limit_err", frame_err, 1'b0);
    end
    tick();
    check("to_at_limit_err", frame_err, 1'b1);
    send(8'h52);
    check_rx("to_back_idle", 3'd1, 1'b0, 1'b1);
    send(HDR);
    send(8'h70);
    check_rx("to_after", 3'd0, 1'b1, 1'b1);
    tick();
    check("to_after_rcvdir_drop", rcvdir, 1'b0);

    // TX single frame, LEFT
    base = txq.size();
    pulse_div(3);
    wait_tx(base + 2, 100);
    if (txq.size() >= base + 2) begin
      check("tx_left_hdr", txq[base], HDR);
      check("tx_left_pay", txq[base + 1], 8'h43);
    end
    repeat (40) tick();
    check("tx_left_count", txq.size(), base + 2);

    // Two ticks during one frame: UP is overwritten by RIGHT
    base = txq.size();
    pulse_div(2);
    repeat (3) tick();
    pulse_div(1);
    repeat (5) tick();
    pulse_div(4);
    wait_tx(base + 4, 150);
    repeat (60) tick();
    check("ovw_count", txq.size(), base + 4);
    if (txq.size() >= base + 4) begin
      check("ovw_hdr0", txq[base], HDR);
      check("ovw_pay0", txq[base + 1], 8'h52);
      check("ovw_hdr1", txq[base + 2], HDR);
      check("ovw_pay1", txq[base + 3], 8'h34);
    end

    // Random RX traffic against a byte-level model
    do_reset();
    m_dir = 0; m_err = 0; m_in = 0; m_idle = 0; quiet = 0;
    for (int c = 0; c < 600; c++) begin
      if (quiet > 0) begin
        quiet--;
        v = 0;
      end else begin
        if ($urandom_range(0, 99) < 3) quiet = $urandom_range(10, 20);
        v = ($urandom_range(0, 99) < 45);
      end
      case ($urandom_range(0, 9))
        0, 1, 2:       b = HDR;
        3, 4, 5, 6:    b = enc($urandom_range(0, 4));
        default:       b = 8'($urandom_range(0, 255));
      endcase
      rx_valid = v;
      rx_data  = b;
      tick();
      e_rcv = 0;
      if (m_in) begin
        if (v) begin
          if (b == HDR) begin
            m_err = 1; m_idle = 0;
          end else if (pay_valid(int'(b))) begin
            m_dir = int'(b) % 8; e_rcv = 1; m_in = 0;
          end else begin
            m_err = 1; m_in = 0;
          end
        end else begin
          m_idle++;
          if (m_idle == int'(TMO)) begin
            m_err = 1; m_in = 0;
          end
        end
      end else if (v && b == HDR) begin
        m_in = 1; m_idle = 0;
      end
      check_rx("rand_rx", 3'(m_dir), e_rcv, m_err);
    end
    rx_valid = 1'b0;

    // Random TX frames, spaced so each tick is sent
    base = txq.size();
    for (int f = 0; f < 8; f++) begin
      int d;
      d = $urandom_range(0, 4);
      pulse_div(d);
      expq.push_back(HDR);
      expq.push_back(enc(d));
      repeat ($urandom_range(30, 45)) tick();
    end
    wait_tx(base + 16, 200);
    for (int i = 0; i < 16; i++) begin
      if (base + i < txq.size()) check($sformatf("rand_tx%0d", i), txq[base + i], expq[i]);
    end

    // Reset while TX is in the payload wait and RX is in the payload state
    do_reset();
    send(HDR);
    send(8'h61);
    send(HDR);
    send(8'h11);
    check_rx("rst2_setup", 3'd1, 1'b0, 1'b1);
    base = txq.size();
    pulse_div(2);
    wait_tx(base + 2, 100);
    send(HDR);
    rst_n = 1'b0;
    tick();
    check("rst2_tx_start", tx_start, 1'b0);
    check("rst2_tx_data", tx_data, 8'h00);
    check_rx("rst2", 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    rcv_seen = 0;
    send(8'h61);
    if (rcvdir) rcv_seen++;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rcvdir) rcv_seen++;
    end
    check("rst2_no_tx", txq.size(), base + 2);
    check("rst2_no_rcvdir", rcv_seen, 0);
    check("rst2_dir2", dir2, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dir_link.md
DIR_LINK -- requirements
Module: dir_link

Interface
REQ-001 SHALL have parameter HEADER, default 8'hA5, frame sync byte.
REQ-002 SHALL have parameter RX_TIMEOUT, default 1_000_000, max clk cycles between header and payload.
REQ-003 SHALL have port clk  input  1  system clock; one clock domain, all logic on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port clk_div  input  1  game tick; its rising edge triggers one TX frame.
REQ-006 SHALL have port dir1  input  direction  local snake direction to transmit.
REQ-007 SHALL have port rx_data  input  8  byte from UART receiver.
REQ-008 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data valid.
REQ-009 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-010 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-011 SHALL have port tx_start  output  1  one-cycle transmit request.
REQ-012 SHALL have port dir2  output  direction  last valid remote direction, feeds move.
REQ-013 SHALL have port rcvdir  output  1  one-cycle pulse on each valid received frame, feeds move.
REQ-014 SHALL have port frame_err  output  1  sticky receive error flag.

Function
REQ-015 SHALL encode directions as a 3-bit code: NONE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4; codes 5-7 invalid.
REQ-016 SHALL frame each direction as two bytes, HEADER then payload {1'b0, ~code[2:0], 1'b0, code[2:0]}.
REQ-017 SHALL detect a clk_div rising edge using a clk_div_prv register; clk_div_prv resets to 1, so there is no spurious edge after reset.
REQ-018 SHALL latch dir1 into a one-deep pending register and set a pending flag on each clk_div edge; a newer edge overwrites an unsent pending value.
REQ-019 SHALL run a TX FSM with states T_IDLE, T_HDR, T_HDR_WAIT, T_PAY, T_PAY_WAIT.
REQ-020 SHALL transition T_IDLE->T_HDR when pending is set; the pending value is moved into a send register and pending is cleared.
REQ-021 SHALL, in T_HDR/T_PAY, assert tx_start for exactly one cycle once tx_busy==0, with tx_data=HEADER or payload respectively, then move to the matching _WAIT state.
REQ-022 SHALL, in _WAIT states, ignore tx_busy in the first cycle and leave once tx_busy==0: T_HDR_WAIT->T_PAY, T_PAY_WAIT->T_IDLE.
REQ-023 SHALL, when a clk_div edge coincides with T_PAY_WAIT exit, latch the new value and start the next frame from T_IDLE on the following cycle.
REQ-024 SHALL run an RX FSM with states R_IDLE and R_PAY, independent of TX.
REQ-025 SHALL, in R_IDLE, go to R_PAY on rx_valid with rx_data==HEADER and clear the timeout counter; all other bytes are ignored without error.
REQ-026 SHALL, in R_PAY, treat an rx_valid byte as valid when bit7==0, bit3==0, [6:4]==~[2:0] and [2:0]<=4.
REQ-027 SHALL, on a valid payload, update dir2 and pulse rcvdir high for one cycle on the next clock edge, then return to R_IDLE; dir2 SHALL hold until the next valid frame.
REQ-028 SHALL, on an invalid payload other than HEADER, set frame_err and return to R_IDLE; dir2 is unchanged and there is no rcvdir pulse.
REQ-029 SHALL, when HEADER arrives in R_PAY, set frame_err, stay in R_PAY and restart the timeout counter (resync).
REQ-030 SHALL count cycles in R_PAY with a counter of width $clog2(RX_TIMEOUT); at RX_TIMEOUT-1 with no byte, it SHALL set frame_err and go to R_IDLE.
REQ-031 SHALL keep frame_err sticky; it is cleared only by reset.

Reset
REQ-032 SHALL, while rst_n==0 at posedge clk, force: tx_start=0, tx_data=0, dir2=NONE, rcvdir=0, frame_err=0, pending=0, timeout counter=0, both FSMs idle.
REQ-033 SHALL abandon any partial TX or RX frame on reset with no tx_start or rcvdir afterwards; there is no resume.

Verification
REQ-034 SHALL cover: rx A5 then 0x61 -> rcvdir high exactly 1 cycle, dir2=UP, frame_err=0.
REQ-035 SHALL cover: rx A5 then 0x11 -> frame_err=1, no rcvdir, dir2 unchanged; then A5, 0x52 -> dir2=DOWN, frame_err stays 1.
REQ-036 SHALL cover: clk_div rise with dir1=LEFT, tx_busy model high 10 cycles after each start -> tx_start pulses with A5, then 0x43 after busy drops.
REQ-037 SHALL cover: RX_TIMEOUT=16, rx A5 then idle 16 cycles -> frame_err=1, R_IDLE; then A5, 0x70 -> dir2=NONE, rcvdir pulse.
REQ-038 SHALL cover: two clk_div edges during one frame with dir1=UP then RIGHT -> next frame payload 0x34 only; UP is never sent.
REQ-039 SHALL cover: rst_n low in T_PAY_WAIT and R_PAY -> all outputs at reset values the next cycle, no further tx_start.
